// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: register file, main
// decoder, j/jr resolution, load-use / jr hazard detection and the ID/EX register.
module id_stage (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [63:0]  if_id,
  input  logic         uart_wait,
  input  logic         id_flush,
  input  logic         ex_mem_read,
  input  logic         ex_reg_write,
  input  logic [4:0]   ex_dst,
  input  logic         mem_mem_read,
  input  logic         mem_reg_write,
  input  logic [4:0]   mem_dst,
  input  logic         wb_en,
  input  logic [4:0]   wb_addr,
  input  logic [31:0]  wb_data,
  output logic         if_pause,
  output logic         if_flush,
  output logic         pcsrc_j,
  output logic         pcsrc_jr,
  output logic [31:0]  jump_address,
  output logic [31:0]  jr_address,
  output logic         exception,
  output logic [31:0]  epc,
  output logic [168:0] id_ex
);

  // ctrl = {RegWrite, MemRead, MemWrite, MemToReg[1:0], ALUSrc, RegDst[1:0], Branch}
  localparam logic [8:0] CTRL_RTYPE  = 9'b1_0_0_00_0_01_0;
  localparam logic [8:0] CTRL_IALU   = 9'b1_0_0_00_1_00_0;
  localparam logic [8:0] CTRL_LW     = 9'b1_1_0_01_1_00_0;
  localparam logic [8:0] CTRL_SW     = 9'b0_0_1_00_1_00_0;
  localparam logic [8:0] CTRL_BRANCH = 9'b0_0_0_00_0_00_1;
  localparam logic [8:0] CTRL_JAL    = 9'b1_0_0_10_0_10_0;
  localparam logic [8:0] CTRL_JALR   = 9'b1_0_0_10_0_01_0;

  logic [31:0] pc_plus4, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [31:0] rs_data, rt_data, ext_imm;
  logic [8:0]  ctrl;
  logic        undefined, reads_rt, zero_ext, is_j, is_jr;
  logic        load_use, jr_hazard, stall, bubble;
  logic [31:0] rf [32];

  assign pc_plus4 = if_id[63:32];
  assign instr    = if_id[31:0];
  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!uart_wait && wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) rs_data = (wb_en && wb_addr == rs) ? wb_data : rf[rs];
    if (rt != 5'd0) rt_data = (wb_en && wb_addr == rt) ? wb_data : rf[rt];
  end

  always_comb begin
    ctrl      = '0;
    undefined = 1'b0;
    reads_rt  = 1'b0;
    zero_ext  = 1'b0;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: begin
            ctrl     = CTRL_RTYPE;
            reads_rt = 1'b1;
          end
          // the all-zero word is the canonical nop and must decode to ctrl 0
          6'h00, 6'h02, 6'h03: begin
            ctrl     = (instr == 32'd0) ? 9'd0 : CTRL_RTYPE;
            reads_rt = 1'b1;
          end
          6'h08: is_jr = 1'b1;
          6'h09: begin
            is_jr = 1'b1;
            ctrl  = CTRL_JALR;
          end
          default: undefined = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0f: ctrl = CTRL_IALU;
      6'h0c, 6'h0d: begin
        ctrl     = CTRL_IALU;
        zero_ext = 1'b1;
      end
      6'h23: ctrl = CTRL_LW;
      6'h2b: begin
        ctrl     = CTRL_SW;
        reads_rt = 1'b1;
      end
      6'h04, 6'h05: begin
        ctrl     = CTRL_BRANCH;
        reads_rt = 1'b1;
      end
      6'h06, 6'h07: ctrl = CTRL_BRANCH;
      6'h01: begin
        if (rt == 5'd0) ctrl = CTRL_BRANCH;
        else            undefined = 1'b1;
      end
      6'h02: is_j = 1'b1;
      6'h03: begin
        is_j = 1'b1;
        ctrl = CTRL_JAL;
      end
      default: undefined = 1'b1;
    endcase
  end

  assign ext_imm = zero_ext ? {16'd0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

  // a load in MEM always writes a register, so mem_mem_read only widens the jr check
  assign load_use  = ex_mem_read && ex_dst != 5'd0 &&
                     (ex_dst == rs || (ex_dst == rt && reads_rt));
  assign jr_hazard = is_jr && rs != 5'd0 &&
                     ((ex_reg_write && ex_dst == rs) ||
                      ((mem_reg_write || mem_mem_read) && mem_dst == rs));
  assign stall     = load_use || jr_hazard;
  assign bubble    = id_flush || stall || undefined;

  assign if_pause     = stall && !id_flush;
  assign pcsrc_j      = is_j  && !stall && !id_flush;
  assign pcsrc_jr     = is_jr && !stall && !id_flush;
  assign if_flush     = pcsrc_j || pcsrc_jr;
  assign exception    = undefined && !pc_plus4[31] && !stall && !id_flush;
  assign jump_address = stall ? 32'd0 : {pc_plus4[31:28], instr[25:0], 2'b00};
  assign jr_address   = stall ? 32'd0 : rs_data;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      id_ex <= '0;
      epc   <= '0;
    end else if (!uart_wait) begin
      id_ex <= bubble ? '0 : {pc_plus4, instr, rs_data, rt_data, ext_imm, ctrl};
      if (exception) epc <= pc_plus4 - 32'd4;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: reset, bypass, hazards, jumps,
// exceptions, flush and freeze with hand-computed expectations.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset_b;
  logic [63:0]  if_id;
  logic         uart_wait, id_flush;
  logic         ex_mem_read, ex_reg_write, mem_mem_read, mem_reg_write;
  logic [4:0]   ex_dst, mem_dst, wb_addr;
  logic         wb_en;
  logic [31:0]  wb_data;
  logic         if_pause, if_flush, pcsrc_j, pcsrc_jr, exception;
  logic [31:0]  jump_address, jr_address, epc;
  logic [168:0] id_ex;
  logic [168:0] held;

  int checks = 0;
  int failures = 0;

  id_stage dut (
    .clk(clk), .reset_b(reset_b), .if_id(if_id), .uart_wait(uart_wait),
    .id_flush(id_flush), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_dst(ex_dst), .mem_mem_read(mem_mem_read), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .if_pause(if_pause), .if_flush(if_flush), .pcsrc_j(pcsrc_j), .pcsrc_jr(pcsrc_jr),
    .jump_address(jump_address), .jr_address(jr_address), .exception(exception),
    .epc(epc), .id_ex(id_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [168:0] obs, input logic [168:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_b = 1'b0; uart_wait = 1'b0; id_flush = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; mem_mem_read = 1'b0; mem_reg_write = 1'b0;
    ex_dst = '0; mem_dst = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    if_id = {32'h0, 32'h00E00008};                       // jr $7
    #1;
    chk("reset_id_ex", id_ex, '0);
    chk("reset_epc", epc, '0);
    chk("reset_reg_read", jr_address, '0);
    tick(); tick();
    reset_b = 1'b1;

    // addu $3,$5,$0 with same-cycle write-back of $5
    if_id = {32'h4, 32'h00A01821};
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    #1;
    chk("bypass_rs", jr_address, 32'h1234);
    tick();
    chk("addu_id_ex", id_ex, {32'h4, 32'h00A01821, 32'h1234, 32'h0, 32'h00001821, 9'h102});
    chk("addu_ctrl", id_ex[8:0], 9'b1_0_0_00_0_01_0);

    // nop while writing $8
    if_id = '0; wb_addr = 5'd8; wb_data = 32'hDEADBEEF;
    tick();
    chk("nop_id_ex", id_ex, '0);

    // load-use: add $9,$8,$8 behind lw $8
    wb_en = 1'b0;
    if_id = {32'h8, 32'h01084820};
    ex_mem_read = 1'b1; ex_dst = 5'd8;
    #1;
    chk("lu_pause", if_pause, 1'b1);
    tick();
    chk("lu_bubble", id_ex, '0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu_release", if_pause, 1'b0);
    tick();
    chk("lu_decode", id_ex, {32'h8, 32'h01084820, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00004820, 9'h102});

    // addi $8,$0,-5 with lw $8 in EX: rt is a destination, no stall
    if_id = {32'hC, 32'h2008FFFB};
    ex_mem_read = 1'b1; ex_dst = 5'd8;
    #1;
    chk("addi_no_stall", if_pause, 1'b0);
    tick();
    chk("addi_sext", id_ex[40:9], 32'hFFFFFFFB);
    chk("addi_ctrl", id_ex[8:0], 9'h108);
    ex_mem_read = 1'b0; ex_dst = '0;

    // jal 0x0100000
    if_id = {32'h44, 32'h0C100000};
    #1;
    chk("jal_pcsrc_j", pcsrc_j, 1'b1);
    chk("jal_if_flush", if_flush, 1'b1);
    chk("jal_addr", jump_address, 32'h00400000);
    tick();
    chk("jal_ctrl", id_ex[8:0], 9'h124);

    // jr $31 behind a register write in MEM
    if_id = {32'h48, 32'h03E00008};
    mem_reg_write = 1'b1; mem_dst = 5'd31;
    #1;
    chk("jr_stall", if_pause, 1'b1);
    chk("jr_stall_pcsrc", pcsrc_jr, 1'b0);
    chk("jr_stall_flush", if_flush, 1'b0);
    tick();
    chk("jr_stall_bubble", id_ex, '0);
    mem_reg_write = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 32'h00400100;
    #1;
    chk("jr_pcsrc", pcsrc_jr, 1'b1);
    chk("jr_flush", if_flush, 1'b1);
    chk("jr_addr", jr_address, 32'h00400100);
    tick();
    chk("jr_ctrl", id_ex[8:0], 9'h0);
    wb_en = 1'b0;

    // undefined opcode in user, then kernel mode
    if_id = {32'h10, 32'hFC000000};
    #1;
    chk("exc_user", exception, 1'b1);
    tick();
    chk("exc_epc", epc, 32'h0000000C);
    chk("exc_bubble", id_ex, '0);
    if_id = {32'h80000010, 32'hFC000000};
    #1;
    chk("exc_kernel", exception, 1'b0);
    tick();
    chk("exc_kernel_bubble", id_ex, '0);
    chk("exc_kernel_epc", epc, 32'h0000000C);

    // j under id_flush, then released
    if_id = {32'h50, 32'h08000010};
    id_flush = 1'b1;
    #1;
    chk("flush_pcsrc_j", pcsrc_j, 1'b0);
    chk("flush_if_flush", if_flush, 1'b0);
    tick();
    chk("flush_bubble", id_ex, '0);
    id_flush = 1'b0;
    #1;
    chk("j_pcsrc", pcsrc_j, 1'b1);
    chk("j_addr", jump_address, 32'h00000040);

    // ori $2,$0,0xF00F, then freeze with a pending write of $6
    if_id = {32'h60, 32'h3402F00F};
    tick();
    held = {32'h60, 32'h3402F00F, 32'h0, 32'h0, 32'h0000F00F, 9'h108};
    chk("ori_id_ex", id_ex, held);
    if_id = {32'h64, 32'h00C03821};                     // addu $7,$6,$0
    uart_wait = 1'b1; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
    tick();
    chk("freeze_id_ex", id_ex, held);
    uart_wait = 1'b0; wb_en = 1'b0;
    tick();
    chk("freeze_no_write", id_ex[104:73], 32'h0);

    // asynchronous reset away from a clock edge
    if_id = {32'h68, 32'h01000008};                     // jr $8
    #3;
    reset_b = 1'b0;
    #1;
    chk("async_id_ex", id_ex, '0);
    chk("async_epc", epc, '0);
    chk("async_rf", jr_address, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage MIPS pipeline. It sits between the fetch stage and the execute stage. It consumes the 64-bit fetch/decode register {PC+4, instruction} and contains the 32×32 register file. It resolves j/jal/jr/jalr, detects load-use and jr hazards, raises undefined-instruction exceptions, and registers a 169-bit decode/execute word.

## Interface
- No parameters.
- clk  in  1  clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- if_id  in  64  {pc_plus4[31:0], instr[31:0]}; pc_plus4[31] is the kernel bit.
- uart_wait  in  1  global freeze; all state holds, including register-file writes.
- id_flush  in  1  taken branch in EX; the instruction in ID is killed.
- ex_mem_read, ex_reg_write  in  1 each  EX-stage load / register-write flags.
- ex_dst  in  5  EX-stage destination register.
- mem_mem_read, mem_reg_write  in  1 each  MEM-stage flags.
- mem_dst  in  5  MEM-stage destination register.
- wb_en  in  1  write-back enable.
- wb_addr  in  5  write-back register address.
- wb_data  in  32  write-back data.
- if_pause  out  1  stall request to fetch (combinational).
- if_flush  out  1  zero the next fetched instruction (combinational).
- pcsrc_j, pcsrc_jr  out  1 each  PCSrc[1] and PCSrc[2] to fetch (combinational).
- jump_address, jr_address  out  32 each  jump targets (combinational).
- exception  out  1  undefined instruction (combinational).
- epc  out  32  registered; reset value 0.
- id_ex  out  169  registered {pc_plus4, instr, rs_data, rt_data, ext_imm, ctrl[8:0]}; reset value 0.

## Operation
- ctrl bit layout: {RegWrite, MemRead, MemWrite, MemToReg[1:0], ALUSrc, RegDst[1:0], Branch}.
  - MemToReg: 0 = ALU, 1 = memory, 2 = pc_plus4.
  - RegDst: 0 = rt, 1 = rd, 2 = $31.
- Supported opcode 0x00 functs: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr, jalr.
- Supported other opcodes:
  - Immediate ALU: addi 08, addiu 09, slti 0a, sltiu 0b, andi 0c, ori 0d, lui 0f.
  - Memory: lw 23, sw 2b.
  - Branch: beq 04, bne 05, blez 06, bgtz 07, bltz 01 (rt = 0).
  - Jump: j 02, jal 03.
- Anything else is undefined.
- ext_imm: zero-extended for andi and ori; sign-extended for all other instructions.
- Register file:
  - $0 always reads 0; writes to $0 are ignored.
  - All registers clear on reset.
  - A write occurs on a clk edge when wb_en && ~uart_wait.
  - Read bypass: if wb_en && wb_addr == rs (or rt) && addr != 0, the read returns wb_data.
- Load-use stall: ex_mem_read && ex_dst != 0 && (ex_dst == rs || (ex_dst == rt && instruction reads rt)).
- jr/jalr stall: (ex_reg_write && ex_dst == rs && rs != 0) || (mem_reg_write && mem_dst == rs && rs != 0).
- Stall response: if_pause = 1, id_ex loads a bubble, and jump/exception outputs are held at 0.
- j/jal (no stall):
  - pcsrc_j = 1, if_flush = 1.
  - jump_address = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jal: RegWrite = 1, RegDst = 2, MemToReg = 2.
- jr/jalr (no stall):
  - pcsrc_jr = 1, if_flush = 1, jr_address = rs_data.
  - jalr: RegDst = 1, MemToReg = 2.
- Exception:
  - exception = 1 for an undefined instruction when pc_plus4[31] == 0.
  - The instruction becomes a bubble and epc <= pc_plus4 - 4.
  - In kernel mode the instruction becomes a bubble with exception = 0.
- id_flush = 1 forces a bubble and gates if_pause, pcsrc_j, pcsrc_jr, if_flush and exception to 0.
- Bubble = all 169 bits zero. The all-zero instruction (sll $0) decodes to ctrl 0.

## Timing
- Decode-to-id_ex latency is 1 cycle; id_ex updates on each rising clk edge when ~uart_wait.
- Control outputs are combinational from if_id and the hazard inputs, valid within the same cycle.
- While stalled, the fetch stage holds if_id, so the same instruction is re-decoded the next cycle.
- Priority, highest first: reset, uart_wait, id_flush, stall, exception, normal decode.
- Reset asserted mid-operation clears id_ex, epc and the register file immediately (asynchronous).

## Test plan
- Reset: hold reset_b = 0 → id_ex = 0, epc = 0, all register reads return 0.
- Write-then-read: wb_en = 1, wb_addr = 5, wb_data = 0x1234 while if_id decodes "addu $3,$5,$0" → rs_data = 0x1234 in the same cycle; next cycle id_ex ctrl = 9'b1_0_0_00_0_01_0.
- Load-use: ex_mem_read = 1, ex_dst = 8, instr "add $9,$8,$8" → if_pause = 1, id_ex = 0 at the next edge; dropping ex_mem_read → normal decode on the following cycle.
- Jumps:
  - jal 0x0100000 at pc_plus4 = 0x0000_0044 → pcsrc_j = 1, if_flush = 1, jump_address = 0x0040_0000, ctrl RegWrite/RegDst = 2/MemToReg = 2.
  - jr $31 with mem_reg_write = 1, mem_dst = 31 → stall and pcsrc_jr = 0.
- Exception: opcode 0x3f at pc_plus4 = 0x0000_0010 → exception = 1, epc = 0x0000_000C, id_ex bubble; the same instruction at pc_plus4 = 0x8000_0010 → exception = 0.
- Flush and freeze:
  - id_flush = 1 during j → pcsrc_j = 0, id_ex = 0.
  - uart_wait = 1 → id_ex and the register file unchanged despite wb_en.
